fifo_burst_reader: RTL and testbench

Read-side burst controller that drains the 32-bit FWFT asymmetric FIFO, which carries packed pairs of 16-bit pixels, and turns its contents into fixed-length write bursts for the frame-buffer memory port. It waits until at least one full burst is buffered, issues a command (address and length), then streams exactly BURST_LEN words with a valid/ready handshake. It advances the frame-buffer address and wraps at end of frame. It runs entirely in the FIFO read clock domain.

---
 rtl/fifo_burst_reader_if.sv | 42 ++++
 rtl/fifo_burst_reader.sv | 158 +++++++++++++++
 tb/tb_fifo_burst_reader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
// Bundles the FIFO read port and the frame-buffer command/write-data port
// that the burst reader sits between.
//   master : burst reader side (pops the FIFO, issues commands, drives wdata)
//   slave  : environment side (FIFO + memory port)
// Signals:
//   fifo_rdata / fifo_rd_valid / fifo_rd_count : FWFT head word, valid, occupancy
//   fifo_rd_en                                  : pop the FIFO head
//   cmd_valid / cmd_ready / cmd_addr / cmd_len  : burst command handshake
//   wdata / wdata_valid / wdata_ready / wdata_last : write data beat handshake
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 11,
    parameter int unsigned ADDR_WIDTH  = 28
);
    logic [DATA_WIDTH-1:0]  fifo_rdata;
    logic                   fifo_rd_valid;
    logic [COUNT_WIDTH-1:0] fifo_rd_count;
    logic                   fifo_rd_en;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [7:0]             cmd_len;

    logic [DATA_WIDTH-1:0]  wdata;
    logic                   wdata_valid;
    logic                   wdata_ready;
    logic                   wdata_last;

    modport master (
        input  fifo_rdata, fifo_rd_valid, fifo_rd_count, cmd_ready, wdata_ready,
        output fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid, wdata_last
    );

    modport slave (
        output fifo_rdata, fifo_rd_valid, fifo_rd_count, cmd_ready, wdata_ready,
        input  fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata, wdata_valid, wdata_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Drains a FWFT FIFO of packed pixel pairs into fixed-length frame-buffer
// write bursts. Waits for a full burst to be buffered, issues one command
// (address, length), streams BURST_LEN beats, then advances the address and
// wraps it at the end of each frame. Single clock domain (FIFO read clock).
// Ports:
//   rd_clk       : clock
//   sys_rst_n    : synchronous active-low reset
//   enable       : gates the start of new bursts (in-flight burst completes)
//   frame_start  : restart addressing at BASE_ADDR
//   bus          : FIFO read port + command/write-data port (master side)
//   frame_done   : one-cycle pulse after the last burst of a frame
//   underrun_err : sticky, FIFO ran dry while the memory port was ready
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned COUNT_WIDTH  = 11,
    parameter int unsigned BURST_LEN    = 64,
    parameter int unsigned ADDR_WIDTH   = 28,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned FRAME_BURSTS = 4050
) (
    input  logic                rd_clk,
    input  logic                sys_rst_n,
    input  logic                enable,
    input  logic                frame_start,
    fifo_burst_reader_if.master bus,
    output logic                frame_done,
    output logic                underrun_err
);

    localparam int unsigned BC_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    localparam logic [ADDR_WIDTH-1:0] BASE_A     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [7:0]            LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [BC_W-1:0]       LAST_BURST = BC_W'(FRAME_BURSTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        NEXT
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [7:0]            beat_cnt_q;
    logic                  fs_pend_q;
    logic                  cmd_valid_q;
    logic                  frame_done_q, frame_done_d;
    logic                  underrun_q;

    logic in_data;
    logic beat_fire;
    logic count_ok;
    logic restart;

    assign in_data   = (state_q == DATA);
    assign beat_fire = in_data & bus.fifo_rd_valid & bus.wdata_ready;
    assign count_ok  = 32'(bus.fifo_rd_count) >= BURST_LEN;

    // A frame_start arriving in NEXT itself is honoured along with any
    // request latched earlier in the burst.
    assign restart = fs_pend_q | frame_start;

    // Address/burst-counter advance applied on the NEXT cycle. End of frame
    // wins over a pending restart so frame_done still fires for a full frame.
    always_comb begin
        addr_d       = addr_q + ADDR_STEP;
        burst_cnt_d  = burst_cnt_q + BC_W'(1);
        frame_done_d = 1'b0;
        if (burst_cnt_q == LAST_BURST) begin
            addr_d       = BASE_A;
            burst_cnt_d  = '0;
            frame_done_d = 1'b1;
        end else if (restart) begin
            addr_d      = BASE_A;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            addr_q       <= BASE_A;
            burst_cnt_q  <= '0;
            beat_cnt_q   <= '0;
            fs_pend_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (in_data && !bus.fifo_rd_valid && bus.wdata_ready) begin
                underrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        addr_q      <= BASE_A;
                        burst_cnt_q <= '0;
                    end
                    if (enable && count_ok) begin
                        state_q     <= CMD;
                        cmd_valid_q <= 1'b1;
                    end
                end
                CMD: begin
                    if (frame_start) begin
                        fs_pend_q <= 1'b1;
                    end
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= DATA;
                    end
                end
                DATA: begin
                    if (frame_start) begin
                        fs_pend_q <= 1'b1;
                    end
                    if (beat_fire) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= NEXT;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                NEXT: begin
                    addr_q       <= addr_d;
                    burst_cnt_q  <= burst_cnt_d;
                    frame_done_q <= frame_done_d;
                    fs_pend_q    <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data path is a straight pass-through of the FWFT head: a pop is the
    // beat transfer itself, so no skid storage is needed.
    assign bus.wdata       = in_data ? bus.fifo_rdata : '0;
    assign bus.wdata_valid = in_data & bus.fifo_rd_valid;
    assign bus.wdata_last  = in_data & bus.fifo_rd_valid & (beat_cnt_q == LAST_BEAT);
    assign bus.fifo_rd_en  = beat_fire;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_addr    = addr_q;
    assign bus.cmd_len     = LAST_BEAT;

    assign frame_done   = frame_done_q;
    assign underrun_err = underrun_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Scoreboard bench: a queue-based FWFT FIFO model feeds the reader; every
// word pushed into the FIFO also lands in the expected-beat queue, and every
// burst loaded pushes its expected command address from a small address model.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 11;
    localparam int unsigned BL = 64;
    localparam int unsigned AW = 28;
    localparam int unsigned FB = 3;

    logic rd_clk      = 1'b0;
    logic sys_rst_n   = 1'b0;
    logic enable      = 1'b0;
    logic frame_start = 1'b0;
    logic frame_done;
    logic underrun_err;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

    fifo_burst_reader #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW),
        .BURST_LEN   (BL),
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (0),
        .FRAME_BURSTS(FB)
    ) dut (
        .rd_clk      (rd_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .frame_start (frame_start),
        .bus         (bus),
        .frame_done  (frame_done),
        .underrun_err(underrun_err)
    );

    always #5 rd_clk = ~rd_clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit pop_pending = 1'b0;
    bit rand_ready  = 1'b0;
    bit valid_gap   = 1'b0;
    bit fs_req      = 1'b0;
    bit rst_req     = 1'b0;

    int unsigned beats      = 0;
    int unsigned beat_idx   = 0;
    int unsigned fd_seen    = 0;
    int unsigned cmd_cycles = 0;

    logic [AW-1:0] m_addr  = '0;
    int unsigned   m_burst = 0;
    int unsigned   exp_fd  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_rd_count = CW'(fifo_q.size());
        bus.fifo_rd_valid = (fifo_q.size() != 0) && !valid_gap;
        bus.fifo_rdata    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // Inputs change 1 ns after the rising edge; the pop decided at the
    // previous sample is applied here, matching a FIFO that advances on the edge.
    task automatic step_edge();
        @(posedge rd_clk);
        #1;
        if (pop_pending) begin
            if (fifo_q.size() == 0) check_eq("pop_on_empty", 1, 0);
            else fifo_q.delete(0);
        end
        pop_pending     = 1'b0;
        frame_start     = fs_req;
        fs_req          = 1'b0;
        sys_rst_n       = !rst_req;
        rst_req         = 1'b0;
        bus.cmd_ready   = 1'b1;
        bus.wdata_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_fifo();
    endtask

    task automatic sample();
        logic acc;
        @(negedge rd_clk);
        acc = bus.wdata_valid & bus.wdata_ready;
        check_eq("fifo_rd_en", bus.fifo_rd_en, acc);
        if (bus.cmd_valid) cmd_cycles++;
        if (bus.cmd_valid && bus.cmd_ready) begin
            if (exp_addr_q.size() == 0) check_eq("cmd_unexpected", 1, 0);
            else check_eq("cmd_addr", bus.cmd_addr, exp_addr_q.pop_front());
            check_eq("cmd_len", bus.cmd_len, BL - 1);
        end
        if (acc) begin
            if (exp_data_q.size() == 0) check_eq("beat_unexpected", 1, 0);
            else check_eq("wdata", bus.wdata, exp_data_q.pop_front());
            check_eq("wdata_last", bus.wdata_last, beat_idx == BL - 1);
            beat_idx = (beat_idx == BL - 1) ? 0 : beat_idx + 1;
            beats++;
        end
        if (frame_done) fd_seen++;
        pop_pending = bus.fifo_rd_en;
    endtask

    task automatic tick();
        step_edge();
        sample();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_data_q.push_back(w);
    endtask

    // Expected address of the burst just loaded, then advance the model.
    task automatic model_burst(input bit fs_during);
        exp_addr_q.push_back(m_addr);
        if (m_burst == FB - 1) begin
            exp_fd++;
            m_addr  = '0;
            m_burst = 0;
        end else if (fs_during) begin
            m_addr  = '0;
            m_burst = 0;
        end else begin
            m_addr  = m_addr + AW'(BL * DW / 8);
            m_burst++;
        end
    endtask

    task automatic load_burst(input logic [DW-1:0] first, input bit fs_during);
        for (int i = 0; i < int'(BL); i++) push_word(first + DW'(i));
        model_burst(fs_during);
    endtask

    task automatic wait_beats(input string tag, input int unsigned n);
        int unsigned target;
        int unsigned cyc;
        target = beats + n;
        cyc    = 0;
        while (beats < target && cyc < 2000) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_beats"}, beats, target);
    endtask

    task automatic settle(input string tag);
        repeat (4) tick();
        check_eq({tag, "_cmd_seen"}, exp_addr_q.size(), 0);
        check_eq({tag, "_frame_done"}, fd_seen, exp_fd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_valid"}, bus.cmd_valid, 0);
        check_eq({tag, "_cmd_addr"}, bus.cmd_addr, 0);
        check_eq({tag, "_cmd_len"}, bus.cmd_len, BL - 1);
        check_eq({tag, "_wdata_valid"}, bus.wdata_valid, 0);
        check_eq({tag, "_wdata_last"}, bus.wdata_last, 0);
        check_eq({tag, "_wdata"}, bus.wdata, 0);
        check_eq({tag, "_fifo_rd_en"}, bus.fifo_rd_en, 0);
        check_eq({tag, "_frame_done"}, frame_done, 0);
        check_eq({tag, "_underrun"}, underrun_err, 0);
    endtask

    initial begin
        int unsigned c0;
        bus.cmd_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        drive_fifo();
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check_reset_outputs("reset");
        enable = 1'b1;

        // Basic burst, data 0..63 at address 0.
        load_burst(0, 1'b0);
        wait_beats("b0", BL);
        settle("b0");

        // One word short of a burst: no command may appear.
        for (int i = 0; i < int'(BL) - 1; i++) push_word(DW'(100 + i));
        c0 = cmd_cycles;
        repeat (20) tick();
        check_eq("below_thresh_cmd", cmd_cycles - c0, 0);
        push_word(DW'(100 + BL - 1));
        model_burst(1'b0);
        tick();
        check_eq("thresh_cmd_early", bus.cmd_valid, 0);
        tick();
        check_eq("thresh_cmd_rise", bus.cmd_valid, 1);
        wait_beats("b1", BL);
        settle("b1");

        // Random write backpressure; last burst of the frame.
        rand_ready = 1'b1;
        load_burst(200, 1'b0);
        wait_beats("b2_rand", BL);
        rand_ready = 1'b0;
        settle("b2_rand");

        // First burst of the next frame wraps to base.
        load_burst(300, 1'b0);
        wait_beats("b3_wrap", BL);
        settle("b3_wrap");

        // frame_start mid-burst: finish at 0x100, restart at base, no frame_done.
        load_burst(400, 1'b1);
        wait_beats("b4_fs", 20);
        fs_req = 1'b1;
        wait_beats("b4_fs_rest", BL - 20);
        settle("b4_fs");

        // FIFO runs dry for 5 cycles with the memory port ready.
        load_burst(500, 1'b0);
        wait_beats("b5_pre", 30);
        check_eq("underrun_before", underrun_err, 0);
        valid_gap = 1'b1;
        repeat (5) tick();
        valid_gap = 1'b0;
        check_eq("underrun_set", underrun_err, 1);
        wait_beats("b5_rest", BL - 30);
        check_eq("underrun_sticky", underrun_err, 1);
        settle("b5_underrun");

        // One-cycle reset mid-burst.
        load_burst(600, 1'b0);
        wait_beats("b6_pre", 30);
        rst_req = 1'b1;
        tick();
        tick();
        check_reset_outputs("midrst");
        fifo_q.delete();
        exp_data_q.delete();
        exp_addr_q.delete();
        beat_idx = 0;
        m_addr   = '0;
        m_burst  = 0;

        load_burst(700, 1'b0);
        wait_beats("b7_after_rst", BL);
        settle("b7_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
